// File: rtl/wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_arbiter_pkg
// Shared definitions for the register-file write-back path. The default
// register geometry (width, count, address width) and the src1 starvation
// limit live here so that wb_arbiter and reg_file agree on them.
// -----------------------------------------------------------------------------
package wb_arbiter_pkg;

    localparam int DEF_REG_WIDTH    = 128;
    localparam int DEF_REG_COUNT    = 32;
    localparam int DEF_ADDR_W       = $clog2(DEF_REG_COUNT);
    localparam int DEF_FIFO_DEPTH   = 2;
    localparam int DEF_STARVE_LIMIT = 4;

    // Which source queue wins the write port this cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_SRC0 = 2'd1,
        GNT_SRC1 = 2'd2
    } grant_e;

    // src0 (single-cycle ALU) normally has priority; once src1 has lost
    // enough arbitrations in a row it is forced through.
    function automatic grant_e arbitrate(input logic has0,
                                         input logic has1,
                                         input logic starved);
        if (has0 && !starved) return GNT_SRC0;
        if (has1)             return GNT_SRC1;
        if (has0)             return GNT_SRC0;
        return GNT_NONE;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Small synchronous FIFO holding (address, data) write-back entries.
// DEPTH must be a power of two so that the pointers wrap naturally.
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   push, push_addr/data  enqueue (ignored while full)
//   pop                   dequeue head (ignored while empty)
//   full, empty           occupancy flags from the registered count
//   head_addr/data        oldest entry
//   entry_valid/addr      per-slot occupancy and address, for hazard masks
// -----------------------------------------------------------------------------
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_REG_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [ADDR_W-1:0]            push_addr,
    input  logic [DATA_W-1:0]            push_data,
    input  logic                         pop,
    output logic                         full,
    output logic                         empty,
    output logic [ADDR_W-1:0]            head_addr,
    output logic [DATA_W-1:0]            head_data,
    output logic [DEPTH-1:0]             entry_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0] entry_addr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; slots are only observed
    // through entry_valid/count, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end
    end

    assign head_addr = addr_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    // A slot is live when its distance from the read pointer (mod DEPTH)
    // is below the current occupancy.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic [PTR_W-1:0] offset;
        assign offset         = PTR_W'(i) - rd_ptr;
        assign entry_valid[i] = ({1'b0, offset} < count);
        assign entry_addr[i]  = addr_mem[i];
    end

endmodule

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Merges write-back results from the single-cycle ALU (src0) and the
// multi-cycle media unit (src1) onto one register-file write port. Each source
// has its own queue; src0 wins by default, src1 is forced after STARVE_LIMIT
// consecutive losses. Address 0 entries are consumed without a write.
//
// Ports
//   clk, reset                        clock, asynchronous active-low reset
//   src0_valid/addr/data, src0_ready  ALU result handshake
//   src1_valid/addr/data, src1_ready  media unit result handshake
//   write_en/addr/data                registered register-file write port
//   pending                           per-register in-flight write mask
// -----------------------------------------------------------------------------
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int REG_WIDTH    = DEF_REG_WIDTH,
    parameter int REG_COUNT    = DEF_REG_COUNT,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    localparam int ADDR_W      = $clog2(REG_COUNT)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 src0_valid,
    input  logic [ADDR_W-1:0]    src0_addr,
    input  logic [REG_WIDTH-1:0] src0_data,
    output logic                 src0_ready,
    input  logic                 src1_valid,
    input  logic [ADDR_W-1:0]    src1_addr,
    input  logic [REG_WIDTH-1:0] src1_data,
    output logic                 src1_ready,
    output logic                 write_en,
    output logic [ADDR_W-1:0]    write_addr,
    output logic [REG_WIDTH-1:0] write_data,
    output logic [REG_COUNT-1:0] pending
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    logic                              full0, full1;
    logic                              empty0, empty1;
    logic [ADDR_W-1:0]                 head0_addr, head1_addr;
    logic [REG_WIDTH-1:0]              head0_data, head1_data;
    logic [FIFO_DEPTH-1:0]             valid0, valid1;
    logic [FIFO_DEPTH-1:0][ADDR_W-1:0] addr0, addr1;

    grant_e               grant;
    logic [SC_W-1:0]      starve_cnt;
    logic [SC_W-1:0]      starve_nxt;
    logic [ADDR_W-1:0]    sel_addr;
    logic [REG_WIDTH-1:0] sel_data;

    // Ready depends only on registered occupancy, never on the inputs.
    assign src0_ready = !full0;
    assign src1_ready = !full1;

    wb_fifo #(.DATA_W(REG_WIDTH), .ADDR_W(ADDR_W), .DEPTH(FIFO_DEPTH)) u_fifo0 (
        .clk        (clk),
        .reset      (reset),
        .push       (src0_valid),
        .push_addr  (src0_addr),
        .push_data  (src0_data),
        .pop        (grant == GNT_SRC0),
        .full       (full0),
        .empty      (empty0),
        .head_addr  (head0_addr),
        .head_data  (head0_data),
        .entry_valid(valid0),
        .entry_addr (addr0)
    );

    wb_fifo #(.DATA_W(REG_WIDTH), .ADDR_W(ADDR_W), .DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk        (clk),
        .reset      (reset),
        .push       (src1_valid),
        .push_addr  (src1_addr),
        .push_data  (src1_data),
        .pop        (grant == GNT_SRC1),
        .full       (full1),
        .empty      (empty1),
        .head_addr  (head1_addr),
        .head_data  (head1_data),
        .entry_valid(valid1),
        .entry_addr (addr1)
    );

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        grant    = arbitrate(!empty0, !empty1, starve_cnt >= SC_W'(STARVE_LIMIT));
        sel_addr = head0_addr;
        sel_data = head0_data;
        if (grant == GNT_SRC1) begin
            sel_addr = head1_addr;
            sel_data = head1_data;
        end
    end

    // Counts consecutive cycles in which src1 waited; saturates at the limit.
    always_comb begin
        starve_nxt = starve_cnt;
        if (empty1 || grant == GNT_SRC1) begin
            starve_nxt = '0;
        end else if (starve_cnt < SC_W'(STARVE_LIMIT)) begin
            starve_nxt = starve_cnt + SC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_nxt;
        end
    end

    // Address and data follow every grant (including address 0), but the
    // strobe is suppressed for address 0 so those entries drain silently.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            write_en   <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
        end else begin
            write_en <= 1'b0;
            if (grant != GNT_NONE) begin
                write_en   <= (sel_addr != '0);
                write_addr <= sel_addr;
                write_data <= sel_data;
            end
        end
    end

    // Hazard mask: anything queued or on the write port right now.
    always_comb begin
        pending = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (valid0[i]) pending[addr0[i]] = 1'b1;
            if (valid1[i]) pending[addr1[i]] = 1'b1;
        end
        if (write_en) pending[write_addr] = 1'b1;
        pending[0] = 1'b0;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter REG_WIDTH, default 128: register data width in bits.
REQ-002 Parameter REG_COUNT, default 32: number of architectural registers; ADDR_W = $clog2(REG_COUNT).
REQ-003 Parameter FIFO_DEPTH, default 2: entries per source queue, power of two, at least 2.
REQ-004 Parameter STARVE_LIMIT, default 4: consecutive lost arbitrations before src1 is forced.
REQ-005 Port clk  in  1  single clock; all state on the rising edge.
REQ-006 Port reset  in  1  asynchronous, active-low reset: 0 resets immediately, release is synchronous to clk.
REQ-007 Ports src0_valid in 1, src0_addr in ADDR_W, src0_data in REG_WIDTH: result from the single-cycle ALU.
REQ-008 Port src0_ready  out  1  src0 queue can accept an entry.
REQ-009 Ports src1_valid in 1, src1_addr in ADDR_W, src1_data in REG_WIDTH: result from the multi-cycle media unit.
REQ-010 Port src1_ready  out  1  src1 queue can accept an entry.
REQ-011 Ports write_en out 1, write_addr out ADDR_W, write_data out REG_WIDTH: register-file write port, all registered.
REQ-012 Port pending  out  REG_COUNT  per-register in-flight write mask for hazard detection.

Function
REQ-013 A source push SHALL occur on a rising edge when srcN_valid and srcN_ready are both 1.
REQ-014 srcN_ready SHALL be 1 exactly when queue N holds fewer than FIFO_DEPTH entries, derived from registered count only with no combinational path from any input.
REQ-015 A push and a pop on the same queue in the same cycle SHALL both take effect, leaving the count unchanged.
REQ-016 Each queue SHALL be FIFO-ordered; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-017 Each cycle, when any queue is non-empty, exactly one head SHALL be granted and popped.
REQ-018 Grant SHALL go to src0 if it is non-empty and starve_cnt < STARVE_LIMIT; otherwise to src1 if it is non-empty; otherwise to src0.
REQ-019 starve_cnt SHALL increment, saturating at STARVE_LIMIT, each cycle src1 is non-empty and not granted.
REQ-020 starve_cnt SHALL clear to 0 when src1 is granted or src1 is empty.
REQ-021 On the edge after a grant, write_addr and write_data SHALL take the popped entry's values.
REQ-022 On that same edge, write_en SHALL be 1 if the popped address is nonzero and 0 if it is zero; an address-0 entry is consumed silently.
REQ-023 In a cycle with no grant, write_en SHALL be 0 on the next edge, and write_addr and write_data SHALL hold their values.
REQ-024 Latency: an entry pushed into an empty queue that wins arbitration immediately SHALL appear on write_* two edges after the push.
REQ-025 pending[k] SHALL be 1 when any valid queue entry has address k, or when write_en=1 and write_addr=k.
REQ-026 pending[0] SHALL always be 0.
REQ-027 pending SHALL be combinational from registered state only.
REQ-028 The block SHALL NOT reorder entries within a source; ordering across sources for the same address is the producers' responsibility.

Reset
REQ-029 While reset=0: both queues empty, src0_ready=src1_ready=1, write_en=0, write_addr=0, write_data=0, starve_cnt=0, pending=0.
REQ-030 Assertion of reset mid-operation SHALL discard all queued entries; no write_en pulse SHALL occur for discarded entries after release.

Structure
REQ-031 A shared package SHALL hold the REG_WIDTH/REG_COUNT defaults, the ADDR_W derivation and the STARVE_LIMIT default, which are also used by reg_file.
REQ-032 A single sub-module wb_fifo SHALL provide the parameterized synchronous FIFO (count, full, empty, head, per-entry valid/address for pending), instantiated once per source.

Verification
REQ-033 src0 push (addr 5, data 0xA5) with src1 idle -> write_en=1, write_addr=5, write_data=0xA5 two edges later; pending[5]=1 from the edge after the push until write_en falls.
REQ-034 src0 valid every cycle with src1 holding one entry (addr 7) -> src0 granted 4 times, then src1 forced on the 5th cycle; write_addr=7 appears exactly once.
REQ-035 src1 pushes 3 entries back-to-back with src1 not granted and FIFO_DEPTH=2 -> src1_ready=0 after the second push; the third entry is accepted only after a pop; order on write_addr is preserved.
REQ-036 src0 push to addr 0 -> entry consumed, write_en stays 0, pending stays 0, src0_ready unaffected afterwards.
REQ-037 Both queues full, reset pulled low for 1 cycle between edges -> outputs zero immediately; no write_en after release; src0_ready=src1_ready=1.
REQ-038 Simultaneous push and pop on a queue holding 1 entry for 10 cycles -> count stays 1, ready stays 1, 10 writes emitted in push order.
